// File: rtl/tych_mac_pkg.sv
// Shared MAC-side types.
//   MAC_DATA_W  : Avalon-ST data width toward/from the MAC
//   mac_avltx_t : one TX beat (data, sop, eop, valid, error, skip_crc)
//   mac_avlrx_t : one RX beat (data, sop, eop, valid, error)
//   tx_arb_state_t : TX arbiter FSM states
package tych_mac_pkg;

  localparam int MAC_DATA_W = 512;

  typedef struct packed {
    logic [MAC_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic                  valid;
    logic                  error;
    logic                  skip_crc;
  } mac_avltx_t;

  typedef struct packed {
    logic [MAC_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic                  valid;
    logic                  error;
  } mac_avlrx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } tx_arb_state_t;

endpackage

// File: rtl/tych_rr_arb.sv
// Combinational round-robin pick.
//   req     : request vector, one bit per source
//   last    : index granted last time; search starts at last+1
//   gnt_oh  : one-hot winner
//   gnt_idx : winner index
//   gnt_vld : at least one request present
module tych_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] cand;

  // Walk last+1 .. last+N (mod N); the first hit wins, later hits are ignored.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(last) + off) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/tych_mac_tx_arb.sv
// Packet-level round-robin arbiter sharing MAC 0 TX among NUM_SRC sources.
// No beat storage: the granted source is muxed straight through and its
// ready is MAC ready. A one-cycle IDLE bubble separates packets.
//   clk, rst        : clock; async active-low reset
//   src_tx          : per-source Avalon-ST TX beats
//   src_ready       : per-source ready (readyLatency 0)
//   src_enable      : 0 keeps a source out of new arbitration
//   mac_0_tx        : beat to MAC 0
//   mac_0_tx_ready  : MAC 0 ready
//   pkt_cnt         : packets completed per source (wrapping)
//   proto_err       : sticky per-source framing error
//   err_clr         : clears all proto_err bits (a same-cycle set wins)
module tych_mac_tx_arb
  import tych_mac_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  mac_avltx_t [NUM_SRC-1:0]        src_tx,
  output logic       [NUM_SRC-1:0]        src_ready,
  input  logic       [NUM_SRC-1:0]        src_enable,
  output mac_avltx_t                      mac_0_tx,
  input  logic                            mac_0_tx_ready,
  output logic [NUM_SRC-1:0][CNT_W-1:0]   pkt_cnt,
  output logic       [NUM_SRC-1:0]        proto_err,
  input  logic                            err_clr
);

  localparam int IDX_W = $clog2(NUM_SRC);

  tx_arb_state_t      state, state_nxt;
  logic [IDX_W-1:0]   grant, last_grant;
  logic               first_beat;

  logic [NUM_SRC-1:0] req, discard, err_set;
  logic [NUM_SRC-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  mac_avltx_t         cur;
  logic               xfer, eop_xfer;

  // Start-of-packet requests compete; a valid non-sop beat in IDLE is a
  // stray mid-packet beat and gets swallowed and flagged.
  always_comb begin
    req     = '0;
    discard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]     = src_tx[i].valid &  src_tx[i].sop & src_enable[i];
      discard[i] = src_tx[i].valid & ~src_tx[i].sop & src_enable[i];
    end
  end

  tych_rr_arb #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .last    (last_grant),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign cur      = src_tx[grant];
  assign xfer     = (state == ST_XFER) && cur.valid && mac_0_tx_ready;
  assign eop_xfer = xfer && cur.eop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and datapath outputs; reset forces outputs quiet without
  // waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    mac_0_tx  = '0;
    src_ready = '0;
    err_set   = '0;
    case (state)
      ST_IDLE: begin
        src_ready = discard;
        err_set   = discard;
        if (arb_vld) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        mac_0_tx         = cur;
        src_ready[grant] = mac_0_tx_ready;
        if (xfer && cur.sop && !first_beat) err_set[grant] = 1'b1;
        if (eop_xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!rst) begin
      mac_0_tx  = '0;
      src_ready = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      first_beat <= 1'b0;
      pkt_cnt    <= '0;
      proto_err  <= '0;
    end else begin
      if (state == ST_IDLE && arb_vld) begin
        grant      <= arb_idx;
        first_beat <= 1'b1;
      end
      if (xfer) first_beat <= 1'b0;
      if (eop_xfer) begin
        last_grant     <= grant;
        pkt_cnt[grant] <= pkt_cnt[grant] + CNT_W'(1);
      end
      proto_err <= (proto_err & {NUM_SRC{~err_clr}}) | err_set;
    end
  end

endmodule

// File: doc/tych_mac_tx_arb.md
TYCH_MAC_TX_ARB -- requirements
Module: tych_mac_tx_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, number of packet sources sharing MAC 0 TX; legal range 2..8.
REQ-002 Parameter CNT_W, default 32, width of each per-source packet counter.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by upstream.
REQ-005 Port src_tx  input  mac_avltx_t[NUM_SRC]  per-source Avalon-ST beat (data 512, sop, eop, valid, error, skip_crc).
REQ-006 Port src_ready  output  NUM_SRC  per-source ready, readyLatency 0.
REQ-007 Port src_enable  input  NUM_SRC  config; 0 excludes source from new arbitration.
REQ-008 Port mac_0_tx  output  mac_avltx_t  beat to MAC 0.
REQ-009 Port mac_0_tx_ready  input  1  MAC 0 ready, readyLatency 0.
REQ-010 Port pkt_cnt  output  CNT_W[NUM_SRC]  packets completed per source.
REQ-011 Port proto_err  output  NUM_SRC  sticky per-source framing error.
REQ-012 Port err_clr  input  1  clears proto_err (all bits).

Function
REQ-013 Transfer = valid && ready on the same cycle; no beat buffering inside the block.
REQ-014 FSM states IDLE and XFER; reset state IDLE.
REQ-015 IDLE: eligible source i = src_tx[i].valid && src_tx[i].sop && src_enable[i].
REQ-016 IDLE: winner = first eligible index scanning from last_grant+1 upward, wrapping modulo NUM_SRC.
REQ-017 IDLE with winner: grant <= winner, go XFER next cycle; no beat consumed in IDLE (1-cycle arbitration bubble).
REQ-018 IDLE: mac_0_tx all fields 0; src_ready[i] = 0 except REQ-019.
REQ-019 IDLE: source with valid=1, sop=0 (and enable=1): src_ready[i]=1, beat discarded, proto_err[i] set.
REQ-020 XFER: mac_0_tx fields = src_tx[grant] fields combinationally; src_ready[grant] = mac_0_tx_ready; all other src_ready 0.
REQ-021 XFER: transfer with eop=1 -> IDLE next cycle, last_grant <= grant, pkt_cnt[grant] += 1 (wraps at 2^CNT_W).
REQ-022 Single-beat packet (sop=eop=1) completes in one XFER cycle.
REQ-023 XFER: sop=1 on a non-first beat is forwarded unchanged and sets proto_err[grant].
REQ-024 error and skip_crc forwarded unchanged; errored packets still counted.
REQ-025 src_enable[grant] falling mid-packet does not abort; packet runs to eop.
REQ-026 Back-to-back: after eop, grant returns to IDLE; same source regains only if no other eligible source (fairness).
REQ-027 proto_err set and err_clr same cycle: set wins.
REQ-028 MAC backpressure unbounded; no timeout.

Reset
REQ-029 rst=0: state IDLE, grant 0, last_grant NUM_SRC-1 (source 0 highest priority first), pkt_cnt 0, proto_err 0.
REQ-030 rst=0: mac_0_tx all fields 0 and src_ready all 0, asynchronously.
REQ-031 Reset mid-packet abandons packet; no eop generated toward MAC.

Structure
REQ-032 mac_avltx_t, mac_avlrx_t and MAC data width constant (512) live in shared package tych_mac_pkg.
REQ-033 Round-robin pick (request vector, last_grant -> one-hot/index) is sub-module tych_rr_arb, purely combinational.
REQ-034 FSM, counters, error flags, mux in tych_mac_tx_arb.

Verification
REQ-035 Src0 3-beat pkt, ready=1 -> bubble cycle, 3 output beats identical to input, pkt_cnt[0]=1.
REQ-036 Src0,1,2 each continuously offer 2-beat pkts -> MAC order 0,1,2,0,1,2; counts equal after 6 pkts.
REQ-037 Src1 single-beat pkt, ready toggled 1/0 -> beat held until ready=1, one transfer, then IDLE.
REQ-038 Src2 valid, sop=0 in IDLE -> src_ready[2]=1 one cycle, proto_err[2]=1; err_clr pulse -> 0.
REQ-039 rst low on beat 2 of 4 -> mac_0_tx.valid=0 same cycle, pkt_cnt 0, next pkt from src0 wins first.
REQ-040 pkt_cnt[3] preset to 2^32-1 via traffic/force -> next eop yields 0.
